// File: rtl/ov5640_burst_wr.sv
// Camera pixel stream to SDRAM burst writer: show-ahead FIFO, fixed-length bursts, frame tracking.
// Define PING_PONG_EN to alternate frames between banks at BASE_ADDR and BASE_ADDR + FRAME_OFFSET.
module ov5640_burst_wr #(
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 24,
  parameter int                BURST_LEN    = 8,
  parameter int                FIFO_DEPTH   = 32,
  parameter int                H_PIXEL      = 640,
  parameter int                V_PIXEL      = 480,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 24'd0,
  parameter logic [ADDR_W-1:0] FRAME_OFFSET = 24'd307200
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              ov5640_vsync,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  input  logic              wr_data_rd,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic              overflow,
  output logic              bank
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TOTAL = H_PIXEL * V_PIXEL;
  localparam int PIX_W = $clog2(TOTAL + 1);
  localparam int BL_W  = $clog2(BURST_LEN);

  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  BURST_C     = CNT_W'(BURST_LEN);
  localparam logic [PIX_W-1:0]  TOTAL_C     = PIX_W'(TOTAL);
  localparam logic [PIX_W-1:0]  BURST_PIX_C = PIX_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BURST_ADR_C = ADDR_W'(BURST_LEN);
  localparam logic [BL_W-1:0]   LAST_BEAT_C = BL_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d, sent_cnt_q, sent_cnt_d;
  logic [BL_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              vsync_dly_q, vsync_dly_d;
  logic              resync_pend_q, resync_pend_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;
  logic              bank_q, bank_d;
`ifdef PING_PONG_EN
  logic              frame_ok_q, frame_ok_d;
`endif

  logic push, pop, burst_done, flush, full, frame_full, drop_full, vsync_rise;

  function automatic logic [ADDR_W-1:0] bank_base(input logic b);
    return b ? BASE_ADDR + FRAME_OFFSET : BASE_ADDR;
  endfunction

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the values of the previous cycle regardless of process order.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // NOTE: every signal assigned in an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!resync_pend_q && count_q >= BURST_C) state_d = REQ;
      REQ:     if (wr_ack) state_d = BURST;
      BURST:   if (burst_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_req     = (state_q == REQ);
    pop        = (state_q == BURST) && wr_data_rd;
    burst_done = pop && (beat_q == LAST_BEAT_C);
    flush      = (state_q == IDLE) && resync_pend_q;
  end

  always_comb begin
    vsync_rise = ov5640_vsync & ~vsync_dly_q;
    full       = (count_q == DEPTH_C);
    frame_full = (pix_cnt_q == TOTAL_C);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push       = pix_valid && !resync_pend_q && !frame_full && (!full || pop);
    drop_full  = pix_valid && !resync_pend_q && !frame_full && full && !pop;

    vsync_dly_d   = ov5640_vsync;
    resync_pend_d = resync_pend_q;
    wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    pix_cnt_d     = push ? pix_cnt_q + PIX_W'(1) : pix_cnt_q;
    sent_cnt_d    = sent_cnt_q;
    beat_d        = beat_q;
    wr_addr_d     = wr_addr_q;
    overflow_d    = overflow_q | drop_full;
    frame_done_d  = 1'b0;
    bank_d        = bank_q;
`ifdef PING_PONG_EN
    frame_ok_d    = frame_ok_q;
`endif

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (pop) beat_d = burst_done ? '0 : beat_q + BL_W'(1);

    if (burst_done) begin
      wr_addr_d    = wr_addr_q + BURST_ADR_C;
      sent_cnt_d   = sent_cnt_q + BURST_PIX_C;
      frame_done_d = (sent_cnt_d == TOTAL_C);
`ifdef PING_PONG_EN
      frame_ok_d   = frame_ok_q | frame_done_d;
`endif
    end

    // Resync only takes effect in IDLE so an accepted burst is never cut short.
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pix_cnt_d  = '0;
      sent_cnt_d = '0;
      overflow_d = 1'b0;
`ifdef PING_PONG_EN
      bank_d     = bank_q ^ frame_ok_q;
      frame_ok_d = 1'b0;
`else
      bank_d     = 1'b0;
`endif
      wr_addr_d  = bank_base(bank_d);
    end

    if (vsync_rise)  resync_pend_d = 1'b1;
    else if (flush)  resync_pend_d = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pix_cnt_q     <= '0;
      sent_cnt_q    <= '0;
      beat_q        <= '0;
      wr_addr_q     <= BASE_ADDR;
      vsync_dly_q   <= 1'b0;
      resync_pend_q <= 1'b0;
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      bank_q        <= 1'b0;
`ifdef PING_PONG_EN
      frame_ok_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pix_cnt_q     <= pix_cnt_d;
      sent_cnt_q    <= sent_cnt_d;
      beat_q        <= beat_d;
      wr_addr_q     <= wr_addr_d;
      vsync_dly_q   <= vsync_dly_d;
      resync_pend_q <= resync_pend_d;
      overflow_q    <= overflow_d;
      frame_done_q  <= frame_done_d;
      bank_q        <= bank_d;
`ifdef PING_PONG_EN
      frame_ok_q    <= frame_ok_d;
`endif
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable through
  // the pointers and count, which are reset.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= pix_data;
  end

  assign wr_data    = mem_q[rd_ptr_q];
  assign wr_addr    = wr_addr_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign bank       = bank_q;

endmodule

// File: tb/tb_ov5640_burst_wr.sv
// Scoreboard bench for ov5640_burst_wr: stimulus queues expected bursts, a monitor checks them.
// A 4x16 frame (64 pixels) keeps frames short while still exercising a 32-deep FIFO.
module tb_ov5640_burst_wr;

  localparam int          BL        = 8;
  localparam int          TOTAL     = 64;
  localparam logic [23:0] FRAME_OFF = 24'd256;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n, ov5640_vsync, pix_valid, wr_req, wr_ack, wr_data_rd;
  logic        frame_done, overflow, bank;
  logic [15:0] pix_data, wr_data;
  logic [23:0] wr_addr;

  typedef struct packed {
    logic [23:0]          addr;
    logic [BL-1:0][15:0]  w;
    logic                 last;
  } burst_t;

  burst_t      exp_q [$];
  logic [15:0] m_words [$];
  logic [23:0] m_addr;
  int          m_sent;
  bit          m_bank, m_prev_done, hold_ack;
  int          outstanding, fd_seen, fd_exp_total;
  int          n_checks, n_err;
  logic [15:0] pv;

  ov5640_burst_wr #(
    .DATA_W(16), .ADDR_W(24), .BURST_LEN(BL), .FIFO_DEPTH(32),
    .H_PIXEL(4), .V_PIXEL(16), .BASE_ADDR(24'd0), .FRAME_OFFSET(FRAME_OFF)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ov5640_vsync(ov5640_vsync),
    .pix_valid(pix_valid), .pix_data(pix_data), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_ack(wr_ack), .wr_data_rd(wr_data_rd), .wr_data(wr_data),
    .frame_done(frame_done), .overflow(overflow), .bank(bank)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out, expected DUT activity within the cycle budget", name);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #3;
  endtask

  task automatic send_pix(input bit acc);
    pix_valid = 1'b1;
    pix_data  = pv;
    tick();
    pix_valid = 1'b0;
    if (acc) m_words.push_back(pv);
    pv++;
  endtask

  task automatic expect_bursts(input int n);
    burst_t b;
    for (int i = 0; i < n; i++) begin
      b.addr = m_addr;
      for (int j = 0; j < BL; j++) b.w[j] = m_words.pop_front();
      m_sent += BL;
      b.last = (m_sent == TOTAL);
      if (b.last) begin
        m_prev_done = 1'b1;
        fd_exp_total++;
      end
      m_addr += 24'(BL);
      exp_q.push_back(b);
      outstanding++;
    end
  endtask

  task automatic model_resync();
`ifdef PING_PONG_EN
    if (m_prev_done) m_bank = ~m_bank;
`endif
    m_prev_done = 1'b0;
    m_sent      = 0;
    m_words.delete();
    m_addr      = m_bank ? FRAME_OFF : 24'd0;
  endtask

  task automatic check_frame_start(input string tag);
    check({tag, "_base_addr"}, wr_addr, m_addr);
    check({tag, "_bank"}, bank, m_bank);
    check({tag, "_overflow_clr"}, overflow, 1'b0);
    check({tag, "_no_req"}, wr_req, 1'b0);
  endtask

  task automatic vsync_frame(input string tag);
    ov5640_vsync = 1'b1;
    tick();
    tick();
    ov5640_vsync = 1'b0;
    model_resync();
    check_frame_start(tag);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (outstanding != 0 && n < 400) begin
      tick();
      n++;
    end
    if (outstanding != 0) fail_timeout(name);
    repeat (3) tick();
  endtask

  task automatic wait_rd(input string name);
    int n;
    n = 0;
    while (wr_data_rd !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (wr_data_rd !== 1'b1) fail_timeout(name);
  endtask

  // SDRAM-side responder: acks a request, then pops one burst on consecutive cycles.
  initial begin : sink
    wr_ack     = 1'b0;
    wr_data_rd = 1'b0;
    forever begin
      @(posedge sys_clk);
      #2;
      if (sys_rst_n === 1'b1 && wr_req === 1'b1 && !hold_ack) begin
        wr_ack = 1'b1;
        @(posedge sys_clk);
        #2;
        wr_ack = 1'b0;
        for (int i = 0; i < BL; i++) begin
          wr_data_rd = 1'b1;
          @(posedge sys_clk);
          #2;
        end
        wr_data_rd = 1'b0;
      end
    end
  end

  initial begin : monitor
    burst_t cur;
    int     k;
    bit     active, chk_fd;
    logic   fd_exp;
    active = 1'b0;
    chk_fd = 1'b0;
    k      = 0;
    fd_exp = 1'b0;
    cur    = '0;
    forever begin
      @(negedge sys_clk);
      if (frame_done === 1'b1) fd_seen++;
      if (chk_fd) begin
        check("frame_done_after_burst", frame_done, fd_exp);
        chk_fd = 1'b0;
        outstanding--;
      end
      if (active && wr_data_rd === 1'b1) begin
        check($sformatf("burst@%0h_word%0d", cur.addr, k), wr_data, cur.w[k]);
        k++;
        if (k == BL) begin
          active = 1'b0;
          chk_fd = 1'b1;
          fd_exp = cur.last;
        end
      end
      if (wr_req === 1'b1 && wr_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_burst: got request at 0x%0h, expected no request", wr_addr);
        end else begin
          cur = exp_q.pop_front();
          check("burst_addr", wr_addr, cur.addr);
          active = 1'b1;
          k = 0;
        end
      end
    end
  end

  initial begin : stimulus
    n_checks = 0; n_err = 0; outstanding = 0; fd_seen = 0; fd_exp_total = 0;
    hold_ack = 1'b0; m_bank = 1'b0; m_prev_done = 1'b0; m_sent = 0; m_addr = 24'd0;
    sys_rst_n = 1'b0; ov5640_vsync = 1'b0; pix_valid = 1'b0; pix_data = 16'h0; pv = 16'h0001;

    repeat (3) tick();
    check("rst_wr_req", wr_req, 1'b0);
    check("rst_wr_addr", wr_addr, 24'd0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_bank", bank, 1'b0);
    sys_rst_n = 1'b1;
    tick();

    // First burst without any vsync, including request latency.
    for (int i = 0; i < BL; i++) send_pix(1'b1);
    expect_bursts(1);
    check("req_latency_low", wr_req, 1'b0);
    tick();
    check("req_latency_high", wr_req, 1'b1);
    check("req_addr", wr_addr, 24'd0);
    wait_drain("first_burst");
    check("addr_after_burst", wr_addr, m_addr);

    // Complete frame, then excess pixels that must be dropped.
    vsync_frame("frame_b");
    for (int i = 0; i < TOTAL; i++) begin
      send_pix(1'b1);
      if ((i + 1) % BL == 0) expect_bursts(1);
    end
    for (int i = 0; i < BL; i++) send_pix(1'b0);
    wait_drain("frame_b");
    check("frame_b_end_addr", wr_addr, m_addr);

    // Overflow with ack held off, then a vsync deferred behind the pending request.
    vsync_frame("frame_c");
    hold_ack = 1'b1;
    for (int i = 0; i < 32; i++) send_pix(1'b1);
    send_pix(1'b0);
    check("overflow_set", overflow, 1'b1);
    check("req_held", wr_req, 1'b1);
    check("req_held_addr", wr_addr, m_addr);
    ov5640_vsync = 1'b1;
    expect_bursts(1);
    tick();
    tick();
    ov5640_vsync = 1'b0;
    check("overflow_kept_until_idle", overflow, 1'b1);
    hold_ack = 1'b0;
    wait_drain("frame_c");
    model_resync();
    check_frame_start("frame_d");

    // Full FIFO with simultaneous push and pop, then vsync in the middle of a burst.
    hold_ack = 1'b1;
    for (int i = 0; i < 32; i++) send_pix(1'b1);
    check("fill_no_overflow", overflow, 1'b0);
    expect_bursts(2);
    hold_ack = 1'b0;
    wait_rd("lockstep_start");
    for (int i = 0; i < BL; i++) send_pix(1'b1);
    check("push_pop_full_no_overflow", overflow, 1'b0);
    wait_rd("second_burst_start");
    tick();
    ov5640_vsync = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send_pix(1'b0);
    ov5640_vsync = 1'b0;
    wait_drain("frame_d");
    model_resync();
    check_frame_start("frame_e");

    // Second complete frame, then two short frames to exercise bank selection.
    for (int i = 0; i < TOTAL; i++) begin
      send_pix(1'b1);
      if ((i + 1) % BL == 0) expect_bursts(1);
    end
    wait_drain("frame_e");
    vsync_frame("frame_f");
    for (int i = 0; i < BL; i++) send_pix(1'b1);
    expect_bursts(1);
    wait_drain("frame_f");
    vsync_frame("frame_g");
    for (int i = 0; i < BL; i++) send_pix(1'b1);
    expect_bursts(1);
    wait_drain("frame_g");

    check("frame_done_pulses", fd_seen, fd_exp_total);
    check("bursts_outstanding", outstanding, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ov5640_burst_wr.md
Name: ov5640_burst_wr

Overview:
- Downstream of the camera capture stage. Accepts the 16-bit RGB565 pixel stream (write-enable plus data) and frame-sync level.
- Buffers pixels in a small show-ahead FIFO.
- Issues fixed-length write bursts with incrementing addresses to the SDRAM write port.
- Tracks frame boundaries, drops excess or overflow pixels, and flags frame completion.

Parameters:
- DATA_W, 16, pixel/word width.
- ADDR_W, 24, burst address width.
- BURST_LEN, 8, words per burst; power of 2, 2..16.
- FIFO_DEPTH, 32, buffer words; power of 2, >= 2*BURST_LEN.
- H_PIXEL, 640, pixels per line.
- V_PIXEL, 480, lines per frame; H_PIXEL*V_PIXEL must be a multiple of BURST_LEN.
- BASE_ADDR, 24'd0, frame start address.
- FRAME_OFFSET, 24'd307200, second-bank offset; used only with PING_PONG_EN.

Ports:
- sys_clk  in  1  single clock; all ports synchronous to it.
- sys_rst_n  in  1  synchronous active-low reset.
- ov5640_vsync  in  1  frame sync level; rising edge marks a new frame.
- pix_valid  in  1  pixel strobe.
- pix_data  in  DATA_W  pixel value.
- wr_req  out  1  burst request.
- wr_addr  out  ADDR_W  burst start address; stable while wr_req=1.
- wr_ack  in  1  one-cycle request acceptance.
- wr_data_rd  in  1  word pop strobe during a burst.
- wr_data  out  DATA_W  FIFO head word (show-ahead).
- frame_done  out  1  one-cycle pulse after a frame's last burst completes.
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full.
- bank  out  1  bank currently being written (0 without PING_PONG_EN).

Behaviour:
- Reset (sys_rst_n=0 at sys_clk edge):
  - FIFO empty; state IDLE.
  - wr_req=0, wr_addr=BASE_ADDR, frame_done=0, overflow=0, bank=0.
  - Pixel count and burst-word count cleared; vsync edge register cleared to 0.
  - wr_data is don't-care while the FIFO is empty.
- Vsync edge: detected with a one-register delay (rise = vsync & ~vsync_d). A rise sets resync_pend.
- Pixel intake, per cycle with pix_valid=1:
  - resync_pend=1 -> drop.
  - pix_cnt == H_PIXEL*V_PIXEL -> drop.
  - FIFO full and no simultaneous pop -> drop, set overflow.
  - Otherwise write to FIFO and increment pix_cnt.
  - Simultaneous push and pop when full is allowed: the pop frees the slot, so the push is accepted.
- State IDLE:
  - If resync_pend=1: flush FIFO, pix_cnt=0, sent_cnt=0, wr_addr=base of the current bank, overflow cleared, resync_pend cleared. Stay in IDLE for that cycle.
  - Else if FIFO count >= BURST_LEN: assert wr_req, go to REQ.
- State REQ:
  - wr_req=1, wr_addr held.
  - On wr_ack=1: wr_req=0 in the next cycle, go to BURST.
  - Resync does not abort a request.
- State BURST:
  - Each wr_data_rd=1 pops one word; wr_data advances the cycle after the pop.
  - After BURST_LEN pops: wr_addr += BURST_LEN (mod 2^ADDR_W), sent_cnt += BURST_LEN, go to IDLE.
  - If sent_cnt now equals H_PIXEL*V_PIXEL, pulse frame_done for one cycle in that same transition.
  - A vsync rise during REQ or BURST is deferred (resync_pend held) until the return to IDLE.
  - wr_data_rd in IDLE or REQ is ignored (no pop).
- Guarantees:
  - wr_req never asserts with fewer than BURST_LEN words buffered.
  - A burst never underflows.
- Latency: a burst becomes requestable 1 cycle after the BURST_LEN-th pixel is written (wr_req rises on the following edge).
- Reset mid-burst: immediate return to the reset state; the partial burst is abandoned.

Optional Feature:
- Macro: PING_PONG_EN.
- When defined:
  - On each resync, if the previous frame produced frame_done, bank toggles.
  - Bank base address = BASE_ADDR + (bank ? FRAME_OFFSET : 0).
  - An incomplete frame rewrites the same bank, so the bank not being written always holds a whole frame.
- When undefined: bank is tied to 0 and every frame starts at BASE_ADDR.

Test Plan:
- Reset, then 8 pixels 16'h0001..16'h0008 with no vsync -> wr_req=1 with wr_addr=0. Ack, then 8 pops -> wr_data sequence 0001..0008, then wr_addr=8.
- Full frame at H_PIXEL=4, V_PIXEL=4, BURST_LEN=8 with the bench popping promptly -> 2 bursts at addresses 0 and 8, one frame_done pulse; a 17th pixel is dropped.
- Hold wr_ack=0 and push 33 pixels with FIFO_DEPTH=32 -> overflow=1, FIFO count stays 32. The next vsync rise in IDLE clears overflow and resets wr_addr to 0.
- Vsync rise mid-BURST -> the burst completes with all 8 words. The flush occurs in the following IDLE cycle, and pixels arriving while resync_pend=1 are not written.
- Same-cycle push and pop on a full FIFO -> both accepted, count stays 32, overflow stays 0.
- PING_PONG_EN with 2 complete frames -> base addresses 0, then FRAME_OFFSET. After an incomplete third frame, the next frame starts again at base 0 (bank stays 0).
